ascon_intr_axil_slave: RTL and testbench

- AXI4-Lite responder that holds the ASCON core's interrupt register file and drives the core's `irq` output.
- Latches interrupt events from core sources (e.g. operation done, tag mismatch) and masks them with per-source and global enables.
- Software clears pending bits through an acknowledge register.
- Sits at the S_AXI_INTR base address, beside the S00_AXI data register slave, in the core's AXI interconnect.

---
 rtl/ascon_intr_axil_slave.sv | 176 +++++++++++++++++
 tb/tb_ascon_intr_axil_slave.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_intr_axil_slave.sv
// AXI4-Lite interrupt controller for the ASCON core: latches source events into ISR,
// masks them with IER/GIE and drives a registered irq output.
module ascon_intr_axil_slave #(
    parameter int          C_NUM_OF_INTR       = 1,
    parameter int          C_S_AXI_DATA_WIDTH  = 32,
    parameter int          C_S_AXI_ADDR_WIDTH  = 5,
    parameter logic [31:0] C_INTR_SENSITIVITY  = 32'hFFFFFFFF,
    parameter logic [31:0] C_INTR_ACTIVE_STATE = 32'hFFFFFFFF,
    parameter int          C_IRQ_SENSITIVITY   = 1,
    parameter bit          C_IRQ_ACTIVE_STATE  = 1'b1
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [C_NUM_OF_INTR-1:0]        intr_src,
    output logic                            irq,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int N  = C_NUM_OF_INTR;
    localparam logic [N-1:0] EDGE_MODE = C_INTR_SENSITIVITY[N-1:0];
    localparam logic [N-1:0] ACT_HIGH  = C_INTR_ACTIVE_STATE[N-1:0];
    localparam logic [2:0] REG_GIE = 3'd0;
    localparam logic [2:0] REG_IER = 3'd1;
    localparam logic [2:0] REG_ISR = 3'd2;
    localparam logic [2:0] REG_IAR = 3'd3;
    localparam logic [2:0] REG_IPR = 3'd4;

    logic                          aw_held, w_held, bvalid, rvalid;
    logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr_q;
    logic [DW-1:0]                 wdata_q, wmask, wbits, ier_wr, rd_mux, rdata;
    logic [DW-1:0]                 ier_ext, isr_ext, ipr_ext;
    logic [DW/8-1:0]               wstrb_q;
    logic                          gie, cond, cond_q, irq_q, irq_set;
    logic [N-1:0]                  ier, isr, src_prev, norm, event_hit, ack;
    logic                          aw_hs, w_hs, ar_hs, commit;
    logic [2:0]                    widx, ridx;

    assign S_AXI_AWREADY = ~ARESET & ~aw_held & ~bvalid;
    assign S_AXI_WREADY  = ~ARESET & ~w_held & ~bvalid;
    assign S_AXI_ARREADY = ~ARESET & ~rvalid;
    assign S_AXI_BVALID  = bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_RVALID  = rvalid;
    assign S_AXI_RRESP   = 2'b00;
    assign S_AXI_RDATA   = rdata;

    assign aw_hs  = S_AXI_AWVALID & S_AXI_AWREADY;
    assign w_hs   = S_AXI_WVALID & S_AXI_WREADY;
    assign ar_hs  = S_AXI_ARVALID & S_AXI_ARREADY;
    assign commit = aw_held & w_held & ~bvalid;
    assign widx   = awaddr_q[4:2];
    assign ridx   = S_AXI_ARADDR[4:2];

    always_comb begin
        wmask   = '0;
        ier_ext = '0;
        isr_ext = '0;
        for (int b = 0; b < DW/8; b++)
            wmask[8*b +: 8] = {8{wstrb_q[b]}};
        ier_ext[N-1:0] = ier;
        isr_ext[N-1:0] = isr;
    end

    assign ipr_ext = isr_ext & ier_ext;
    assign wbits   = wdata_q & wmask;
    assign ier_wr  = (ier_ext & ~wmask) | wbits;
    assign ack     = (commit && widx == REG_IAR) ? wbits[N-1:0] : '0;

    // Sources are normalised so that 1 always means "active"; edge bits look for 0->1.
    assign norm      = intr_src ^ ~ACT_HIGH;
    assign event_hit = (EDGE_MODE & norm & ~src_prev) | (~EDGE_MODE & norm);

    always_comb begin
        rd_mux = '0;
        case (ridx)
            REG_GIE: rd_mux[0] = gie;
            REG_IER: rd_mux    = ier_ext;
            REG_ISR: rd_mux    = isr_ext;
            REG_IPR: rd_mux    = ipr_ext;
            default: rd_mux    = '0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            bvalid   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
        end else begin
            if (aw_hs) begin
                aw_held  <= 1'b1;
                awaddr_q <= S_AXI_AWADDR;
            end
            if (w_hs) begin
                w_held  <= 1'b1;
                wdata_q <= S_AXI_WDATA;
                wstrb_q <= S_AXI_WSTRB;
            end
            if (commit) begin
                bvalid <= 1'b1;
            end else if (bvalid && S_AXI_BREADY) begin
                bvalid  <= 1'b0;
                aw_held <= 1'b0;
                w_held  <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_mux;
        end else if (rvalid && S_AXI_RREADY) begin
            rvalid <= 1'b0;
        end
    end

    // A same-cycle event beats the acknowledge for that bit.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gie      <= 1'b0;
            ier      <= '0;
            isr      <= '0;
            src_prev <= '0;
        end else begin
            src_prev <= norm;
            isr      <= (isr & ~ack) | event_hit;
            if (commit && widx == REG_GIE && wstrb_q[0])
                gie <= wdata_q[0];
            if (commit && widx == REG_IER)
                ier <= ier_wr[N-1:0];
        end
    end

    assign cond    = gie & |(isr & ier);
    assign irq_set = (C_IRQ_SENSITIVITY != 0) ? cond : (cond & ~cond_q);

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            cond_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            cond_q <= cond;
            irq_q  <= irq_set;
        end
    end

    assign irq = irq_q ^ ~C_IRQ_ACTIVE_STATE;

    logic unused;
    assign unused = ^{S_AXI_AWPROT, S_AXI_ARPROT, awaddr_q, S_AXI_ARADDR, ier_wr, wbits};
endmodule

// File: tb/tb_ascon_intr_axil_slave.sv
// Bench for ascon_intr_axil_slave: directed checks with literal values, then random AXI
// traffic and interrupt sources checked every cycle against a register-level model.
module tb_ascon_intr_axil_slave;
    localparam int          N    = 4;
    localparam logic [31:0] SENS = 32'hFFFFFFF5;  // bits 0,2 edge; 1,3 level
    localparam logic [31:0] ACT  = 32'hFFFFFFF9;  // bits 1,2 active-low
    localparam logic [3:0]  SRC_IDLE = ~ACT[3:0];

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic [3:0]  intr_src = SRC_IDLE;
    logic        irq;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 1;
    logic        arvalid = 0, arready, rvalid, rready = 1;
    logic [31:0] wdata = '0, rdata;
    logic [3:0]  wstrb = 4'hF;
    logic [1:0]  bresp, rresp;

    int total = 0, bad = 0;
    bit started = 0;

    ascon_intr_axil_slave #(
        .C_NUM_OF_INTR(N), .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(5),
        .C_INTR_SENSITIVITY(SENS), .C_INTR_ACTIVE_STATE(ACT),
        .C_IRQ_SENSITIVITY(1), .C_IRQ_ACTIVE_STATE(1'b1)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET), .intr_src(intr_src), .irq(irq),
        .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid),
        .S_AXI_AWREADY(awready), .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb),
        .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready), .S_AXI_BRESP(bresp),
        .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready), .S_AXI_ARADDR(araddr),
        .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
        .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid),
        .S_AXI_RREADY(rready)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic timeout(input string nm);
        total++;
        bad++;
        $display("FAIL %s: no handshake within bound at %0t", nm, $time);
    endtask

    // Register-level model: register contents plus which channel slots are occupied.
    bit          m_gie, m_aw, m_w, m_bv, m_rv, m_irq;
    logic [3:0]  m_ier, m_isr, m_prev, m_strb;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata, m_rdata;

    function automatic logic [31:0] model_read(input int idx);
        case (idx)
            0: return {31'd0, m_gie};
            1: return {28'd0, m_ier};
            2: return {28'd0, m_isr};
            4: return {28'd0, m_isr & m_ier};
            default: return 32'd0;
        endcase
    endfunction

    always @(posedge ACLK) begin
        logic [31:0] mask, bits;
        logic [3:0]  nrm, ev, ack;
        bit          aw_ok, w_ok, next_irq;
        started = 1;
        if (ARESET) begin
            m_gie = 0; m_ier = 0; m_isr = 0; m_prev = 0;
            m_aw = 0; m_w = 0; m_bv = 0; m_rv = 0; m_irq = 0; m_rdata = 0;
        end else begin
            next_irq = m_gie && ((m_isr & m_ier) != 0);
            aw_ok = awvalid && !m_aw && !m_bv;
            w_ok  = wvalid && !m_w && !m_bv;
            if (arvalid && !m_rv) begin
                m_rdata = model_read(int'(araddr) / 4);
                m_rv = 1;
            end else if (m_rv && rready) m_rv = 0;
            ack = 0;
            if (m_aw && m_w && !m_bv) begin
                for (int b = 0; b < 4; b++) mask[8*b +: 8] = m_strb[b] ? 8'hFF : 8'h00;
                bits = m_wdata & mask;
                case (int'(m_addr) / 4)
                    0: if (m_strb[0]) m_gie = m_wdata[0];
                    1: m_ier = (m_ier & ~mask[3:0]) | bits[3:0];
                    3: ack = bits[3:0];
                    default: ;
                endcase
                m_bv = 1;
            end else if (m_bv && bready) begin
                m_bv = 0; m_aw = 0; m_w = 0;
            end
            if (aw_ok) begin m_aw = 1; m_addr = awaddr; end
            if (w_ok) begin m_w = 1; m_wdata = wdata; m_strb = wstrb; end
            nrm = intr_src ^ ~ACT[3:0];
            ev = 0;
            for (int i = 0; i < 4; i++)
                ev[i] = SENS[i] ? (nrm[i] && !m_prev[i]) : nrm[i];
            m_isr = (m_isr & ~ack) | ev;
            m_prev = nrm;
            m_irq = next_irq;
        end
    end

    always @(negedge ACLK) begin
        if (started) begin
            chk("awready", awready, !ARESET && !m_aw && !m_bv);
            chk("wready", wready, !ARESET && !m_w && !m_bv);
            chk("bvalid", bvalid, m_bv);
            chk("bresp", bresp, 0);
            chk("arready", arready, !ARESET && !m_rv);
            chk("rvalid", rvalid, m_rv);
            if (m_rv) chk("rdata", rdata, m_rdata);
            chk("rresp", rresp, 0);
            chk("irq", irq, m_irq);
        end
    end

    task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        bit ad = 0, wd = 0;
        awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
        while (!(ad && wd) && n < 50) begin
            @(negedge ACLK);
            if (awvalid && awready) ad = 1;
            if (wvalid && wready) wd = 1;
            @(posedge ACLK); #1;
            if (ad) awvalid = 0;
            if (wd) wvalid = 0;
            n++;
        end
        if (!(ad && wd)) begin timeout("wr_addr_data"); awvalid = 0; wvalid = 0; return; end
        n = 0;
        do begin @(negedge ACLK); n++; end while (!bvalid && n < 50);
        if (!bvalid) timeout("wr_resp");
        @(posedge ACLK); #1;
    endtask

    task automatic axi_read(input logic [4:0] a, output logic [31:0] d);
        int n = 0;
        bit ad = 0;
        araddr = a; arvalid = 1; rready = 1; d = 'x;
        while (!ad && n < 50) begin
            @(negedge ACLK);
            if (arready) ad = 1;
            @(posedge ACLK); #1;
            n++;
        end
        arvalid = 0;
        if (!ad) begin timeout("rd_addr"); return; end
        n = 0;
        do begin @(negedge ACLK); n++; end while (!rvalid && n < 50);
        if (!rvalid) begin timeout("rd_data"); return; end
        d = rdata;
        @(posedge ACLK); #1;
    endtask

    initial begin
        logic [31:0] d;
        int awcnt, bcnt;
        bit awdone, wdone;

        repeat (3) @(posedge ACLK);
        #1 ARESET = 0;
        @(negedge ACLK);
        chk("reset_irq", irq, 0);
        chk("reset_bvalid", bvalid, 0);
        axi_read(5'h00, d); chk("reset_gie", d, 0);
        axi_read(5'h04, d); chk("reset_ier", d, 0);
        axi_read(5'h08, d); chk("reset_isr", d, 0);
        axi_read(5'h10, d); chk("reset_ipr", d, 0);

        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h1, 4'hF);
        intr_src[0] = 1;
        @(posedge ACLK); #1 intr_src[0] = 0;
        @(negedge ACLK); chk("irq_1cyc_after_pulse", irq, 0);
        @(negedge ACLK); chk("irq_2cyc_after_pulse", irq, 1);
        axi_read(5'h08, d); chk("isr_after_pulse", d, 32'h1);
        axi_read(5'h10, d); chk("ipr_after_pulse", d, 32'h1);
        @(negedge ACLK); chk("irq_held", irq, 1);
        @(posedge ACLK); #1;

        axi_write(5'h0C, 32'h1, 4'hF);
        @(negedge ACLK); chk("irq_after_ack", irq, 0);
        @(posedge ACLK); #1;
        axi_read(5'h10, d); chk("ipr_after_ack", d, 0);
        axi_read(5'h0C, d); chk("iar_reads_zero", d, 0);

        // Ack commits in the same cycle as a fresh edge on bit 0.
        intr_src[0] = 1;
        repeat (3) @(posedge ACLK);
        #1 intr_src[0] = 0;
        awaddr = 5'h0C; wdata = 32'h1; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 1;
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; intr_src[0] = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK); chk("irq_set_wins", irq, 1);
        end
        @(posedge ACLK); #1;
        axi_read(5'h08, d); chk("isr_set_wins", d, 32'h1);

        // AW three cycles ahead of W, BREADY held low for four response cycles.
        awcnt = 0; bcnt = 0; awdone = 0; wdone = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge ACLK); #1;
            if (awdone) awvalid = 0;
            if (wdone) wvalid = 0;
            if (c == 0) begin awvalid = 1; awaddr = 5'h04; bready = 0; end
            if (c == 3) begin wvalid = 1; wdata = 32'h3; wstrb = 4'hF; end
            if (c == 9) bready = 1;
            @(negedge ACLK);
            if (awvalid && awready) begin awcnt++; awdone = 1; end
            if (wvalid && wready) wdone = 1;
            if (bvalid) bcnt++;
        end
        chk("aw_single_handshake", awcnt, 1);
        chk("bvalid_cycles", bcnt, 5);
        @(posedge ACLK); #1;
        axi_read(5'h04, d); chk("ier_once", d, 32'h3);

        axi_write(5'h18, 32'hDEADBEEF, 4'hF);
        axi_read(5'h18, d); chk("unmapped_read", d, 0);
        axi_read(5'h00, d); chk("gie_unchanged", d, 32'h1);
        axi_read(5'h04, d); chk("ier_unchanged", d, 32'h3);

        araddr = 5'h00; arvalid = 1; rready = 0;
        @(posedge ACLK); #1 arvalid = 0;
        @(negedge ACLK); chk("rvalid_pending", rvalid, 1);
        @(posedge ACLK); #1 ARESET = 1;
        @(posedge ACLK); #1 ARESET = 0;
        @(negedge ACLK); chk("rvalid_dropped", rvalid, 0);
        rready = 1;
        intr_src = SRC_IDLE;

        for (int c = 0; c < 3000; c++) begin
            bit awf, wf, arf;
            @(negedge ACLK);
            awf = awvalid && awready;
            wf  = wvalid && wready;
            arf = arvalid && arready;
            @(posedge ACLK); #1;
            if (!awvalid || awf) begin
                awvalid = ($urandom % 3) == 0;
                awaddr = 5'($urandom % 32);
            end
            if (!wvalid || wf) begin
                wvalid = ($urandom % 3) == 0;
                wdata = ($urandom % 2) ? $urandom : 32'($urandom % 16);
                wstrb = 4'($urandom % 16);
            end
            if (!arvalid || arf) begin
                arvalid = ($urandom % 2) == 0;
                araddr = 5'($urandom % 32);
            end
            bready = ($urandom % 2) == 0;
            rready = ($urandom % 2) == 0;
            if (($urandom % 4) == 0) intr_src = 4'($urandom % 16);
            ARESET = ($urandom % 400) == 0;
        end
        @(posedge ACLK); #1;
        awvalid = 0; wvalid = 0; arvalid = 0; ARESET = 0;
        repeat (4) @(posedge ACLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
